// File: rtl/common_types_pkg.sv
// Shared types for the memory-side blocks: word type, RAM handshake state
// and the arbiter FSM state.
package common_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    RAM_IDLE,
    RAM_WAIT,
    RAM_DONE
  } ram_state_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IGRANT,
    ARB_DGRANT
  } arb_state_t;

  // Byte enables used for every read (full word).
  localparam logic [3:0] STRB_WORD = 4'b1111;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between an instruction-fetch port and a
// data port. Data wins simultaneous requests by default; with ARB_FAIR_EN
// defined, simultaneous requests alternate between the two ports.
// RAM command and completion signals are combinational from the grant state.
module mem_arbiter #(
  parameter int unsigned WORD_W = common_types_pkg::WORD_W
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          iREN,
  input  logic [WORD_W-1:0]             iaddr,
  output logic [WORD_W-1:0]             iload,
  output logic                          iHIT,
  input  logic                          dREN,
  input  logic                          dWEN,
  input  logic [WORD_W-1:0]             daddr,
  input  logic [WORD_W-1:0]             dstore,
  input  logic [3:0]                    dstrb,
  output logic [WORD_W-1:0]             dload,
  output logic                          dHIT,
  output logic                          ramREN,
  output logic                          ramWEN,
  output logic [WORD_W-1:0]             ramaddr,
  output logic [WORD_W-1:0]             ramstore,
  output logic [3:0]                    ramstrb,
  input  logic [WORD_W-1:0]             ramload,
  input  common_types_pkg::ram_state_t  ramstate
);

  import common_types_pkg::*;

  arb_state_t state;
  arb_state_t next_state;
  logic       d_req;
  logic       d_first;

  assign d_req = dREN | dWEN;

`ifdef ARB_FAIR_EN
  // High when the fetch port was granted last; reset so data wins the first tie.
  logic last_grant;

  // Remember which port took the most recent grant.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_grant <= 1'b1;
    end else if (state == ARB_IDLE && next_state == ARB_IGRANT) begin
      last_grant <= 1'b1;
    end else if (state == ARB_IDLE && next_state == ARB_DGRANT) begin
      last_grant <= 1'b0;
    end
  end

  assign d_first = last_grant;
`else
  assign d_first = 1'b1;
`endif

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Grant selection in idle; a grant is held until the RAM reports done.
  always_comb begin
    next_state = state;
    unique case (state)
      ARB_IDLE: begin
        if (d_req && (!iREN || d_first)) begin
          next_state = ARB_DGRANT;
        end else if (iREN) begin
          next_state = ARB_IGRANT;
        end
      end
      ARB_IGRANT, ARB_DGRANT: begin
        if (ramstate == RAM_DONE) begin
          next_state = ARB_IDLE;
        end
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  // Mirror the granted port onto the RAM and return completion to it only.
  always_comb begin
    ramREN   = '0;
    ramWEN   = '0;
    ramaddr  = '0;
    ramstore = '0;
    ramstrb  = '0;
    iHIT     = '0;
    iload    = '0;
    dHIT     = '0;
    dload    = '0;
    unique case (state)
      ARB_IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        ramstrb = STRB_WORD;
        if (ramstate == RAM_DONE) begin
          iHIT  = 1'b1;
          iload = ramload;
        end
      end
      ARB_DGRANT: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        ramstrb  = dWEN ? dstrb : STRB_WORD;
        if (ramstate == RAM_DONE) begin
          dHIT  = 1'b1;
          dload = ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Honours ARB_FAIR_EN when defined.
module tb_mem_arbiter;
  import common_types_pkg::*;

`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [3:0]  strb;
    logic        ihit;
    logic [31:0] iload;
    logic        dhit;
    logic [31:0] dload;
  } obs_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [3:0]  dstrb;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iHIT, dHIT, ramREN, ramWEN;
  logic [3:0]  ramstrb;
  ram_state_t  ramstate;

  int checks = 0;
  int errors = 0;

  obs_t got, want;

  // Reference model: who owns the RAM (0 none, 1 fetch, 2 data) and who was served last.
  int owner = 0;
  int last_served = 1;

  mem_arbiter #(.WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iHIT(iHIT),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dstrb(dstrb),
    .dload(dload), .dHIT(dHIT),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramstrb(ramstrb), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  function automatic obs_t model_out();
    obs_t o;
    o = '0;
    if (nRST === 1'b1) begin
      if (owner == 1) begin
        o.ren  = 1'b1;
        o.addr = iaddr;
        o.strb = 4'hF;
        if (ramstate == RAM_DONE) begin
          o.ihit  = 1'b1;
          o.iload = ramload;
        end
      end else if (owner == 2) begin
        o.ren   = dREN;
        o.wen   = dWEN;
        o.addr  = daddr;
        o.store = dstore;
        o.strb  = dWEN ? dstrb : 4'hF;
        if (ramstate == RAM_DONE) begin
          o.dhit  = 1'b1;
          o.dload = ramload;
        end
      end
    end
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.ren = ramREN; o.wen = ramWEN; o.addr = ramaddr; o.store = ramstore;
    o.strb = ramstrb; o.ihit = iHIT; o.iload = iload; o.dhit = dHIT; o.dload = dload;
    return o;
  endfunction

  // One clock: sample outputs and model prediction, then advance the model across the edge.
  task automatic tick();
    bit dq, iq, done, rst_ok;
    #1;
    got  = sample();
    want = model_out();
    dq = dREN | dWEN;
    iq = iREN;
    done = (ramstate == RAM_DONE);
    rst_ok = (nRST === 1'b1);
    @(posedge CLK);
    if (!rst_ok) begin
      owner = 0;
    end else if (owner == 0) begin
      if (dq && iq) owner = (FAIR && last_served == 2) ? 1 : 2;
      else if (dq) owner = 2;
      else if (iq) owner = 1;
      if (owner != 0) last_served = owner;
    end else if (done) begin
      owner = 0;
    end
    #1;
  endtask

  task automatic drop_all();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = RAM_IDLE;
  endtask

  task automatic test_reset();
    nRST = 0; iREN = 1; dREN = 1; dWEN = 0; ramstate = RAM_DONE;
    iaddr = 32'h44; daddr = 32'h88; dstore = 32'h1; dstrb = 4'h1; ramload = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (got !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", got); end
    end
    // Release with only a fetch pending: no grant until the next edge.
    dREN = 0; ramstate = RAM_IDLE; nRST = 1;
    tick();
    checks++;
    if (got !== '0) begin errors++; $display("FAIL reset_release_idle got %h want 0", got); end
    ramstate = RAM_DONE; ramload = 32'h0BAD_F00D;
    tick();
    checks++;
    if (got !== want || got.ihit !== 1'b1) begin errors++; $display("FAIL reset_first_grant got %h want %h", got, want); end
    drop_all();
    tick();
  endtask

  task automatic test_fetch();
    iREN = 1; iaddr = 32'h100; ramstate = RAM_WAIT; ramload = 32'h1111_2222;
    tick();
    checks++;
    if (got !== '0) begin errors++; $display("FAIL fetch_idle got %h want 0", got); end
    tick();
    checks++;
    if (got !== want || got.ren !== 1'b1 || got.addr !== 32'h100 || got.ihit !== 1'b0)
      begin errors++; $display("FAIL fetch_wait got %h want %h", got, want); end
    ramstate = RAM_DONE; ramload = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (got !== want || got.ihit !== 1'b1 || got.iload !== 32'hDEAD_BEEF || got.strb !== 4'hF)
      begin errors++; $display("FAIL fetch_done got %h want %h", got, want); end
    drop_all();
    tick();
    checks++;
    if (got !== '0) begin errors++; $display("FAIL fetch_after got %h want 0", got); end
  endtask

  task automatic test_priority();
    iREN = 1; iaddr = 32'h300; dWEN = 1; daddr = 32'h200; dstore = 32'h1234_5678; dstrb = 4'b0011;
    ramstate = RAM_DONE; ramload = 32'h5555_AAAA;
    tick();
    tick();
    checks++;
    if (got !== want || got.wen !== 1'b1 || got.strb !== 4'b0011 || got.addr !== 32'h200 ||
        got.store !== 32'h1234_5678 || got.dhit !== 1'b1 || got.ihit !== 1'b0)
      begin errors++; $display("FAIL priority_data got %h want %h", got, want); end
    dWEN = 0;
    tick();
    tick();
    checks++;
    if (got !== want || got.ihit !== 1'b1 || got.addr !== 32'h300 || got.dhit !== 1'b0)
      begin errors++; $display("FAIL priority_fetch got %h want %h", got, want); end
    drop_all();
    tick();
  endtask

  task automatic test_fairness();
    string order;
    string expect_order;
    expect_order = FAIR ? "DIDI" : "DDDD";
    order = "";
    iREN = 1; dREN = 1; ramstate = RAM_DONE;
    for (int i = 0; i < 16 && order.len() < 4; i++) begin
      iaddr = $urandom; daddr = $urandom; ramload = $urandom;
      tick();
      checks++;
      if (got !== want) begin errors++; $display("FAIL fair_cycle%0d got %h want %h", i, got, want); end
      if (got.dhit) order = {order, "D"};
      if (got.ihit) order = {order, "I"};
    end
    checks++;
    if (order != expect_order) begin errors++; $display("FAIL fair_order got %s want %s", order, expect_order); end
    drop_all();
    ramstate = RAM_DONE;
    tick();
    ramstate = RAM_IDLE;
    tick();
  endtask

  task automatic test_reset_midgrant();
    obs_t now;
    dWEN = 1; daddr = 32'hABC0; dstore = 32'h77; dstrb = 4'b1000; ramstate = RAM_WAIT;
    tick();
    tick();
    checks++;
    if (got !== want || got.wen !== 1'b1) begin errors++; $display("FAIL midrst_grant got %h want %h", got, want); end
    nRST = 0;
    owner = 0;
    #1;
    now = sample();
    checks++;
    if (now !== '0) begin errors++; $display("FAIL midrst_outputs got %h want 0", now); end
    ramstate = RAM_DONE;
    #1;
    checks++;
    if (dHIT !== 1'b0) begin errors++; $display("FAIL midrst_dhit got %b want 0", dHIT); end
    tick();
    nRST = 1; drop_all();
    tick();
    checks++;
    if (got !== '0) begin errors++; $display("FAIL midrst_after got %h want 0", got); end
  endtask

  task automatic test_wait_stall();
    obs_t first;
    dREN = 1; daddr = $urandom; dstore = $urandom; ramstate = RAM_IDLE;
    tick();
    ramstate = RAM_WAIT;
    for (int i = 0; i < 10; i++) begin
      ramload = $urandom;
      tick();
      if (i == 0) first = got;
      checks++;
      if (got !== want || got !== first || got.ren !== 1'b1 || got.dhit !== 1'b0)
        begin errors++; $display("FAIL stall_cycle%0d got %h want %h", i, got, want); end
    end
    ramstate = RAM_DONE;
    tick();
    checks++;
    if (got !== want || got.dhit !== 1'b1) begin errors++; $display("FAIL stall_done got %h want %h", got, want); end
    drop_all();
    tick();
  endtask

  task automatic test_back_to_back();
    dREN = 1; ramstate = RAM_DONE;
    for (int i = 0; i < 12; i++) begin
      daddr = $urandom; ramload = $urandom;
      tick();
      checks++;
      if (got !== want || got.dhit !== 1'(i % 2) || got.iload !== 32'h0)
        begin errors++; $display("FAIL b2b_cycle%0d got %h want %h", i, got, want); end
    end
    drop_all();
    tick();
  endtask

  task automatic test_random();
    bit ipend, dpend;
    int istart, dstart;
    ipend = 0; dpend = 0; istart = 0; dstart = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!ipend && $urandom_range(0, 2) == 0) begin
        ipend = 1; istart = cyc; iREN = 1; iaddr = $urandom;
      end
      if (!dpend && $urandom_range(0, 2) == 0) begin
        dpend = 1; dstart = cyc;
        if ($urandom_range(0, 1) == 1) dREN = 1; else dWEN = 1;
        daddr = $urandom; dstore = $urandom; dstrb = 4'($urandom);
      end
      ramstate = ram_state_t'(2'($urandom_range(0, 2)));
      ramload = $urandom;
      tick();
      checks++;
      if (got !== want || (got.ihit && got.dhit))
        begin errors++; $display("FAIL rand_cycle%0d got %h want %h", cyc, got, want); end
      if (got.ihit) begin
        checks++;
        if (cyc - istart < 1) begin errors++; $display("FAIL rand_ilatency got %0d want >=1", cyc - istart); end
        ipend = 0; iREN = 0;
      end
      if (got.dhit) begin
        checks++;
        if (cyc - dstart < 1) begin errors++; $display("FAIL rand_dlatency got %0d want >=1", cyc - dstart); end
        dpend = 0; dREN = 0; dWEN = 0;
      end
    end
    drop_all();
    ramstate = RAM_DONE;
    tick();
    ramstate = RAM_IDLE;
    tick();
  endtask

  initial begin
    nRST = 0; iREN = 0; dREN = 0; dWEN = 0; iaddr = '0; daddr = '0; dstore = '0;
    dstrb = '0; ramload = '0; ramstate = RAM_IDLE;
    test_reset();
    test_fetch();
    test_priority();
    test_fairness();
    test_reset_midgrant();
    test_wait_stall();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
